int_seq: RTL and testbench
==========================

// Module: int_seq
// PURPOSE
//  Interrupt sequencer sitting directly upstream of CP0. Captures external interrupt edges, applies the CP0
//  mask and global enable, and picks the highest-priority pending source at an instruction boundary.
//  It then drives CP0's EPC write (resume PC), redirects the PC to the source vector, and on ERET
//  redirects the PC back to CP0's EPC. Only one level is serviced; no nesting.
// PARAMETERS
//  NUM_IRQ    4             number of interrupt sources; index 0 = highest priority
//  VEC_BASE   32'h0000_0800 vector address of source 0
//  VEC_SHIFT  4             vector stride = 1<<VEC_SHIFT bytes per source
// PORTS
//  clk          in   1        system clock, all state on rising edge
//  clr          in   1        synchronous active-high reset
//  irq          in   NUM_IRQ  raw requests; rising edge sets pending bit
//  irq_mask     in   NUM_IRQ  per-source enable from CP0 status (1 = enabled)
//  ie           in   1        global interrupt enable from CP0
//  pend_clr     in   NUM_IRQ  software clear of pending bits (one-cycle pulse per bit)
//  instr_valid  in   1        an instruction retires this cycle = legal boundary
//  pc_next      in   32       resume address valid when instr_valid=1
//  eret         in   1        ERET retires this cycle
//  epc_q        in   32       current EPC value read back from CP0 (EPC_out)
//  epc_din      out  32       value for CP0 EPC_in
//  epc_we       out  1        one-cycle EPC write strobe for CP0 EPC_WE
//  redirect     out  1        one-cycle PC override strobe
//  redirect_pc  out  32       target PC while redirect=1
//  pending      out  NUM_IRQ  pending register
//  in_service   out  1        high from ENTER until RETURN completes
//  cur_src      out  $clog2(NUM_IRQ)  index of source being serviced
// BEHAVIOUR
//  Reset (clr=1 at clk edge): state=IDLE; pending, irq_q, epc_din, epc_we, redirect, redirect_pc,
//   in_service, cur_src all 0. Reset wins over every other event, including mid-entry/service.
//  Edge detect: irq_q <= irq; pending[i] <= (pending[i] & ~pend_clr[i] & ~ack[i]) | (irq[i] & ~irq_q[i]).
//   A new edge in the same cycle as clear/ack leaves the bit set (set wins).
//  eligible = pending & irq_mask; take = ie & |eligible.
//  FSM:
//   IDLE:    if take & instr_valid -> ENTER; latch sel = lowest set index of eligible, epc_din = pc_next,
//            ack[sel]=1 (pending bit cleared next edge). No take or no boundary -> stay.
//   ENTER:   epc_we=1, redirect=1, redirect_pc = VEC_BASE + (sel << VEC_SHIFT), in_service=1,
//            cur_src=sel -> SERVICE. Exactly one cycle.
//   SERVICE: in_service=1; new requests only accumulate in pending. eret -> RETURN.
//   RETURN:  redirect=1, redirect_pc = epc_q (sampled this cycle), in_service=1 -> IDLE.
//  Latency: boundary cycle N -> epc_we/redirect in cycle N+1; eret cycle M -> redirect in M+1.
//  eret outside SERVICE is ignored (no redirect). instr_valid outside IDLE is ignored.
//  A request pending on RETURN exit is taken at the first boundary in IDLE (earliest 1 cycle later).
//  Vector address arithmetic is 32-bit unsigned, wraps modulo 2^32.
//  epc_we and redirect are registered outputs, never asserted combinationally from inputs.
// STRUCTURE
//  Shared package: FSM state encoding (IDLE/ENTER/SERVICE/RETURN), default VEC_BASE.
//  One sub-module natural: prio_enc (NUM_IRQ one-hot/multi-hot -> lowest index + valid).
// TESTING
//  1 ie=1, mask=4'b1111, irq[2] rises, instr_valid=1, pc_next=32'h100 -> next cycle epc_we=1,
//    epc_din=32'h100, redirect_pc=32'h820, cur_src=2, pending[2]=0.
//  2 irq[1] and irq[3] rise together, boundary -> cur_src=1, redirect_pc=32'h810; pending=4'b1000 held
//    through SERVICE; after eret+RETURN, next boundary takes src 3 (redirect_pc=32'h830).
//  3 In SERVICE with epc_q=32'h104, eret=1 -> next cycle redirect=1, redirect_pc=32'h104, then IDLE,
//    in_service=0.
//  4 ie=0 or mask[0]=0 with pending[0]=1, instr_valid pulsing -> no epc_we/redirect; pending[0] stays 1;
//    pend_clr[0] pulse -> pending[0]=0; edge coincident with pend_clr -> bit stays 1.
//  5 clr asserted in ENTER and in SERVICE -> next cycle all outputs 0, state IDLE, pending 0.
//  6 eret in IDLE, irq held high (no new edge) -> no redirect, no new pending bit.

Source files
------------

// File: rtl/int_seq_pkg.sv
// Shared definitions for the interrupt sequencer.
//   state_e        : sequencer FSM encoding
//   VecBaseDefault : default vector address of source 0
//   vec_addr()     : vector address of a source, 32-bit wrapping arithmetic
package int_seq_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StEnter   = 2'd1,
        StService = 2'd2,
        StReturn  = 2'd3
    } state_e;

    localparam logic [31:0] VecBaseDefault = 32'h0000_0800;

    function automatic logic [31:0] vec_addr(input logic [31:0] base, input logic [31:0] idx,
                                             input int unsigned shift);
        return base + (idx << shift);
    endfunction

endpackage

// File: rtl/int_seq_if.sv
// Signal bundle between the core/CP0 side (master) and the interrupt sequencer (slave).
//   irq, irq_mask, ie, pend_clr    : request inputs, CP0 mask/enable, software pending clear
//   instr_valid, pc_next, eret     : retirement information from the pipeline
//   epc_q                          : EPC read back from CP0
//   epc_din, epc_we                : EPC write to CP0
//   redirect, redirect_pc          : PC override
//   pending, in_service, cur_src   : status
interface int_seq_if #(
    parameter int unsigned NUM_IRQ = 4
);
    localparam int unsigned IdxW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

    logic [NUM_IRQ-1:0] irq;
    logic [NUM_IRQ-1:0] irq_mask;
    logic               ie;
    logic [NUM_IRQ-1:0] pend_clr;
    logic               instr_valid;
    logic [31:0]        pc_next;
    logic               eret;
    logic [31:0]        epc_q;
    logic [31:0]        epc_din;
    logic               epc_we;
    logic               redirect;
    logic [31:0]        redirect_pc;
    logic [NUM_IRQ-1:0] pending;
    logic               in_service;
    logic [IdxW-1:0]    cur_src;

    modport master (
        output irq, irq_mask, ie, pend_clr, instr_valid, pc_next, eret, epc_q,
        input  epc_din, epc_we, redirect, redirect_pc, pending, in_service, cur_src
    );

    modport slave (
        input  irq, irq_mask, ie, pend_clr, instr_valid, pc_next, eret, epc_q,
        output epc_din, epc_we, redirect, redirect_pc, pending, in_service, cur_src
    );

endinterface

// File: rtl/int_seq_prio_enc.sv
// Priority encoder: index of the lowest set bit of req_i (index 0 = highest priority).
//   req_i   : request vector
//   idx_o   : lowest set index (0 when no request)
//   valid_o : any request set
module int_seq_prio_enc #(
    parameter int unsigned Width = 4,
    parameter int unsigned IdxW  = 2
) (
    input  logic [Width-1:0] req_i,
    output logic [IdxW-1:0]  idx_o,
    output logic             valid_o
);

    always_comb begin
        idx_o = '0;
        // Scan downwards so the lowest set index is the last one written.
        for (int i = int'(Width) - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o = IdxW'(i);
            end
        end
    end

    assign valid_o = |req_i;

endmodule

// File: rtl/int_seq.sv
// Interrupt sequencer upstream of CP0. Captures request edges into a pending register, picks the
// highest-priority enabled source at an instruction boundary, writes the resume PC to CP0 EPC,
// redirects to the source vector, and redirects back to EPC on ERET. Single level, no nesting.
//   clk : clock, rising edge
//   clr : synchronous active-high reset
//   bus : int_seq_if slave modport (requests, retirement info, EPC/redirect outputs, status)
module int_seq
    import int_seq_pkg::*;
#(
    parameter int unsigned NUM_IRQ   = 4,
    parameter logic [31:0] VEC_BASE  = VecBaseDefault,
    parameter int unsigned VEC_SHIFT = 4
) (
    input logic      clk,
    input logic      clr,
    int_seq_if.slave bus
);

    localparam int unsigned IdxW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

    state_e             state_q, state_d;
    logic [NUM_IRQ-1:0] pending_q, pending_d;
    logic [NUM_IRQ-1:0] irq_q;
    logic [NUM_IRQ-1:0] eligible;
    logic [NUM_IRQ-1:0] ack;
    logic               take;
    logic               sel_valid;
    logic [IdxW-1:0]    sel;
    logic [IdxW-1:0]    cur_src_q, cur_src_d;
    logic [31:0]        epc_din_q, epc_din_d;
    logic [31:0]        redirect_pc_q, redirect_pc_d;
    logic               epc_we_q;
    logic               redirect_q;
    logic               in_service_q;

    assign eligible = pending_q & bus.irq_mask;
    assign take     = bus.ie & sel_valid;

    int_seq_prio_enc #(
        .Width (NUM_IRQ),
        .IdxW  (IdxW)
    ) u_prio_enc (
        .req_i   (eligible),
        .idx_o   (sel),
        .valid_o (sel_valid)
    );

    always_comb begin
        state_d       = state_q;
        ack           = '0;
        cur_src_d     = cur_src_q;
        epc_din_d     = epc_din_q;
        redirect_pc_d = redirect_pc_q;
        unique case (state_q)
            StIdle: begin
                if (take && bus.instr_valid) begin
                    state_d       = StEnter;
                    ack[sel]      = 1'b1;
                    cur_src_d     = sel;
                    epc_din_d     = bus.pc_next;
                    redirect_pc_d = vec_addr(VEC_BASE, 32'(sel), VEC_SHIFT);
                end
            end
            StEnter:   state_d = StService;
            StService: begin
                if (bus.eret) begin
                    state_d       = StReturn;
                    redirect_pc_d = bus.epc_q;
                end
            end
            StReturn:  state_d = StIdle;
            default:   state_d = StIdle;
        endcase
        // A fresh edge wins over a software clear or an acknowledge in the same cycle.
        pending_d = (pending_q & ~bus.pend_clr & ~ack) | (bus.irq & ~irq_q);
    end

    // Strobes are derived from the next state so they come straight out of flops.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q       <= StIdle;
            pending_q     <= '0;
            irq_q         <= '0;
            cur_src_q     <= '0;
            epc_din_q     <= '0;
            redirect_pc_q <= '0;
            epc_we_q      <= 1'b0;
            redirect_q    <= 1'b0;
            in_service_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            pending_q     <= pending_d;
            irq_q         <= bus.irq;
            cur_src_q     <= cur_src_d;
            epc_din_q     <= epc_din_d;
            redirect_pc_q <= redirect_pc_d;
            epc_we_q      <= (state_d == StEnter);
            redirect_q    <= (state_d == StEnter) || (state_d == StReturn);
            in_service_q  <= (state_d != StIdle);
        end
    end

    assign bus.epc_din     = epc_din_q;
    assign bus.epc_we      = epc_we_q;
    assign bus.redirect    = redirect_q;
    assign bus.redirect_pc = redirect_pc_q;
    assign bus.pending     = pending_q;
    assign bus.in_service  = in_service_q;
    assign bus.cur_src     = cur_src_q;

endmodule

// File: tb/tb_int_seq.sv
// Directed self-checking bench for int_seq.
module tb_int_seq;

    logic clk;
    logic clr;
    int   total;
    int   bad;

    int_seq_if #(.NUM_IRQ(4)) bus ();

    int_seq #(
        .NUM_IRQ   (4),
        .VEC_BASE  (32'h0000_0800),
        .VEC_SHIFT (4)
    ) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outs(input string tag);
        chk({tag, ".epc_we"}, 32'(bus.epc_we), 32'd0);
        chk({tag, ".redirect"}, 32'(bus.redirect), 32'd0);
        chk({tag, ".in_service"}, 32'(bus.in_service), 32'd0);
    endtask

    initial begin
        total           = 0;
        bad             = 0;
        clr             = 1'b1;
        bus.irq         = 4'b0000;
        bus.irq_mask    = 4'b1111;
        bus.ie          = 1'b1;
        bus.pend_clr    = 4'b0000;
        bus.instr_valid = 1'b0;
        bus.pc_next     = 32'h0;
        bus.eret        = 1'b0;
        bus.epc_q       = 32'h0;
        step();
        step();
        clr = 1'b0;

        // Reset state
        chk_idle_outs("rst");
        chk("rst.pending", 32'(bus.pending), 32'h0);
        chk("rst.cur_src", 32'(bus.cur_src), 32'h0);
        chk("rst.epc_din", bus.epc_din, 32'h0);
        chk("rst.redirect_pc", bus.redirect_pc, 32'h0);

        // 1: single source 2
        bus.irq = 4'b0100;
        step();
        chk("t1.pending_set", 32'(bus.pending), 32'h4);
        chk_idle_outs("t1.no_boundary");
        bus.instr_valid = 1'b1;
        bus.pc_next     = 32'h100;
        step();
        chk("t1.epc_we", 32'(bus.epc_we), 32'd1);
        chk("t1.redirect", 32'(bus.redirect), 32'd1);
        chk("t1.epc_din", bus.epc_din, 32'h100);
        chk("t1.redirect_pc", bus.redirect_pc, 32'h820);
        chk("t1.cur_src", 32'(bus.cur_src), 32'd2);
        chk("t1.pending_ack", 32'(bus.pending), 32'h0);
        chk("t1.in_service", 32'(bus.in_service), 32'd1);
        bus.instr_valid = 1'b0;
        step();
        chk("t1.svc_epc_we", 32'(bus.epc_we), 32'd0);
        chk("t1.svc_redirect", 32'(bus.redirect), 32'd0);
        chk("t1.svc_in_service", 32'(bus.in_service), 32'd1);

        // 3: return through EPC
        bus.epc_q = 32'h104;
        bus.eret  = 1'b1;
        step();
        bus.eret = 1'b0;
        chk("t3.redirect", 32'(bus.redirect), 32'd1);
        chk("t3.redirect_pc", bus.redirect_pc, 32'h104);
        chk("t3.in_service", 32'(bus.in_service), 32'd1);
        chk("t3.epc_we", 32'(bus.epc_we), 32'd0);
        step();
        chk_idle_outs("t3.idle");

        // 2: simultaneous sources 1 and 3
        bus.irq = 4'b1010;
        step();
        chk("t2.pending_both", 32'(bus.pending), 32'ha);
        bus.instr_valid = 1'b1;
        bus.pc_next     = 32'h200;
        step();
        chk("t2.cur_src", 32'(bus.cur_src), 32'd1);
        chk("t2.redirect_pc", bus.redirect_pc, 32'h810);
        chk("t2.epc_din", bus.epc_din, 32'h200);
        chk("t2.pending_left", 32'(bus.pending), 32'h8);
        step();  // instr_valid still high, ignored outside IDLE
        step();
        chk("t2.svc_pending", 32'(bus.pending), 32'h8);
        chk("t2.svc_epc_we", 32'(bus.epc_we), 32'd0);
        chk("t2.svc_redirect", 32'(bus.redirect), 32'd0);
        chk("t2.svc_cur_src", 32'(bus.cur_src), 32'd1);
        bus.instr_valid = 1'b0;
        bus.epc_q       = 32'h204;
        bus.eret        = 1'b1;
        step();
        bus.eret = 1'b0;
        chk("t2.ret_pc", bus.redirect_pc, 32'h204);
        step();
        chk_idle_outs("t2.idle");
        chk("t2.idle_pending", 32'(bus.pending), 32'h8);
        bus.instr_valid = 1'b1;
        bus.pc_next     = 32'h300;
        step();
        bus.instr_valid = 1'b0;
        chk("t2.second_redirect", 32'(bus.redirect), 32'd1);
        chk("t2.second_pc", bus.redirect_pc, 32'h830);
        chk("t2.second_src", 32'(bus.cur_src), 32'd3);
        chk("t2.second_pending", 32'(bus.pending), 32'h0);
        step();
        bus.epc_q = 32'h304;
        bus.eret  = 1'b1;
        step();
        bus.eret = 1'b0;
        step();

        // 6: eret in IDLE with irq held high
        bus.eret = 1'b1;
        step();
        bus.eret = 1'b0;
        chk("t6.redirect", 32'(bus.redirect), 32'd0);
        chk("t6.pending", 32'(bus.pending), 32'h0);
        chk("t6.in_service", 32'(bus.in_service), 32'd0);

        // 4: masking, software clear, set-wins
        bus.irq = 4'b0000;
        step();
        bus.ie  = 1'b0;
        bus.irq = 4'b0001;
        step();
        chk("t4.pending0", 32'(bus.pending), 32'h1);
        bus.instr_valid = 1'b1;
        step();
        step();
        chk_idle_outs("t4.ie_off");
        chk("t4.ie_off_pending", 32'(bus.pending), 32'h1);
        bus.ie       = 1'b1;
        bus.irq_mask = 4'b1110;
        step();
        step();
        chk_idle_outs("t4.masked");
        chk("t4.masked_pending", 32'(bus.pending), 32'h1);
        bus.instr_valid = 1'b0;
        bus.irq_mask    = 4'b1111;
        bus.pend_clr    = 4'b0001;
        step();
        bus.pend_clr = 4'b0000;
        chk("t4.sw_clear", 32'(bus.pending), 32'h0);
        bus.irq = 4'b0000;
        step();
        bus.irq = 4'b0001;
        step();
        bus.irq = 4'b0000;
        step();
        bus.irq      = 4'b0001;
        bus.pend_clr = 4'b0001;
        step();
        bus.pend_clr = 4'b0000;
        bus.irq      = 4'b0000;
        chk("t4.set_wins", 32'(bus.pending), 32'h1);

        // 5: reset during ENTER
        bus.irq         = 4'b1000;
        bus.instr_valid = 1'b1;
        bus.pc_next     = 32'h400;
        step();
        bus.instr_valid = 1'b0;
        chk("t5.enter_pc", bus.redirect_pc, 32'h800);
        chk("t5.enter_pending", 32'(bus.pending), 32'h8);
        clr     = 1'b1;
        bus.irq = 4'b0000;
        step();
        clr = 1'b0;
        chk_idle_outs("t5.clr_enter");
        chk("t5.clr_enter_pending", 32'(bus.pending), 32'h0);
        chk("t5.clr_enter_pc", bus.redirect_pc, 32'h0);
        chk("t5.clr_enter_epc", bus.epc_din, 32'h0);
        chk("t5.clr_enter_src", 32'(bus.cur_src), 32'h0);

        // 5: reset during SERVICE
        bus.irq = 4'b0010;
        step();
        bus.instr_valid = 1'b1;
        bus.pc_next     = 32'h500;
        step();
        bus.instr_valid = 1'b0;
        step();
        chk("t5.svc_in_service", 32'(bus.in_service), 32'd1);
        bus.irq = 4'b0110;
        step();
        chk("t5.svc_accum", 32'(bus.pending), 32'h4);
        clr     = 1'b1;
        bus.irq = 4'b0000;
        step();
        clr = 1'b0;
        chk_idle_outs("t5.clr_svc");
        chk("t5.clr_svc_pending", 32'(bus.pending), 32'h0);
        chk("t5.clr_svc_src", 32'(bus.cur_src), 32'h0);
        bus.eret  = 1'b1;
        bus.epc_q = 32'h999;
        step();
        bus.eret = 1'b0;
        chk("t5.post_clr_idle", 32'(bus.redirect), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
